// File: rtl/traffic_pkg.sv
// traffic_pkg: shared segment codes, digit-select codes and state types for the lane display monitor
package traffic_pkg;
    localparam logic [7:0] SEG_0    = 8'b00000011;
    localparam logic [7:0] SEG_1    = 8'b10011111;
    localparam logic [7:0] SEG_2    = 8'b00100101;
    localparam logic [7:0] SEG_3    = 8'b00001101;
    localparam logic [7:0] SEG_4    = 8'b10011001;
    localparam logic [7:0] SEG_5    = 8'b01001001;
    localparam logic [7:0] SEG_6    = 8'b01000001;
    localparam logic [7:0] SEG_7    = 8'b00011111;
    localparam logic [7:0] SEG_8    = 8'b00000001;
    localparam logic [7:0] SEG_9    = 8'b00001001;
    localparam logic [7:0] SEG_DASH = 8'b11111101;
    localparam logic [1:0] CS_TENS  = 2'b10;
    localparam logic [1:0] CS_UNITS = 2'b01;
    localparam logic [1:0] CS_BLANK = 2'b11;
    typedef enum logic [1:0] {S_BLANK, S_WAIT_TENS, S_HAVE_TENS} scan_t;
    typedef enum logic [1:0] {L_RED, L_YEL, L_GRN, L_BAD} lamp_t;
    function automatic lamp_t lamp_state(input logic d, input logic v, input logic x);
        return {d, v, x} == 3'b100 ? L_RED :
               {d, v, x} == 3'b010 ? L_YEL :
               {d, v, x} == 3'b001 ? L_GRN : L_BAD;
    endfunction
    // The only legal changes are the green->yellow->red->green cycle; manual mode permits no extra steps
    function automatic logic lamp_step_ok(input lamp_t prev, input lamp_t cur);
        return (prev == L_GRN && cur == L_YEL) || (prev == L_YEL && cur == L_RED) ||
               (prev == L_RED && cur == L_GRN);
    endfunction
endpackage

// File: rtl/traffic_display_monitor_if.sv
// traffic_display_monitor_if: one lane's display bus plus the monitor's check results
//   seg/cs: active-low segment byte and digit select; lamp_d/v/x: red/yellow/green lamps
//   count/count_valid/manual/seg_err/seq_err/lamp_err: monitor results
//   master drives the lane bus, slave is the monitor
interface traffic_display_monitor_if;
    logic [7:0] seg;
    logic [1:0] cs;
    logic       lamp_d;
    logic       lamp_v;
    logic       lamp_x;
    logic [4:0] count;
    logic       count_valid;
    logic       manual;
    logic       seg_err;
    logic       seq_err;
    logic       lamp_err;
    modport master (output seg, cs, lamp_d, lamp_v, lamp_x,
                    input count, count_valid, manual, seg_err, seq_err, lamp_err);
    modport slave (input seg, cs, lamp_d, lamp_v, lamp_x,
                   output count, count_valid, manual, seg_err, seq_err, lamp_err);
endinterface

// File: rtl/traffic_display_monitor_seg7_decode.sv
// seg7_decode: maps an active-low segment byte to a digit, flagging legal digits and the dash
//   in seg[7:0]; out digit[3:0], is_digit, is_dash
module seg7_decode
    import traffic_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] digit,
    output logic       is_digit,
    output logic       is_dash
);
    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end
    assign is_dash = seg == SEG_DASH;
endmodule

// File: rtl/traffic_display_monitor.sv
// traffic_display_monitor: decodes a lane's scanned countdown display and flags segment, sequence and lamp errors
//   clk, reset (sync, active-high); bus: traffic_display_monitor_if.slave
//   DISP_MON_SEQCHK_EN: when defined, builds the countdown sequence check; otherwise seq_err is tied low
module traffic_display_monitor
    import traffic_pkg::*;
#(
    parameter int STABLE_PAIRS = 4,
    parameter int MAX_COUNT    = 29
) (
    input logic clk,
    input logic reset,
    traffic_display_monitor_if.slave bus
);
    localparam logic [3:0] STABLE = 4'(STABLE_PAIRS);
    localparam logic [6:0] MAX    = 7'(MAX_COUNT);
    scan_t      state_q, state_d;
    lamp_t      prev_q, lamp_cur;
    logic [3:0] tens_q, tens_d, cnt_q, cnt_d, digit;
    logic [4:0] cand_q, cand_d, count_q, count_d;
    logic [6:0] pair_w;
    logic       is_digit, is_dash, seg_bad;
    logic       cv_q, cv_d, manual_q, seg_err_q, seg_err_d, lamp_err_q, lamp_err_d;
`ifdef DISP_MON_SEQCHK_EN
    logic       first_q, first_d, seq_err_q, seq_err_d;
`endif
    seg7_decode u_dec (.seg(bus.seg), .digit(digit), .is_digit(is_digit), .is_dash(is_dash));
    // 7-bit sum so a tens digit above 2 still reads as out of range instead of wrapping
    assign pair_w   = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1) + {3'b000, digit};
    assign seg_bad  = bus.cs == 2'b00 || (bus.cs == CS_BLANK ? !is_dash : !is_digit);
    assign lamp_cur = lamp_state(bus.lamp_d, bus.lamp_v, bus.lamp_x);
    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        cv_d       = 1'b0;
        seg_err_d  = 1'b0;
`ifdef DISP_MON_SEQCHK_EN
        first_d    = first_q;
        seq_err_d  = 1'b0;
`endif
        // A previous sample of L_BAD (also the reset value) skips the transition check
        lamp_err_d = lamp_cur == L_BAD ||
                     (prev_q != L_BAD && lamp_cur != prev_q && !lamp_step_ok(prev_q, lamp_cur));
        if (seg_bad) begin
            seg_err_d = 1'b1;
        end else if (bus.cs == CS_BLANK) begin
            state_d = S_BLANK;
            cand_d  = '0;
            cnt_d   = '0;
`ifdef DISP_MON_SEQCHK_EN
            first_d = 1'b1;
`endif
        end else if (bus.cs == CS_TENS) begin
            state_d = S_HAVE_TENS;
            tens_d  = digit;
        end else if (state_q == S_HAVE_TENS) begin
            state_d = S_WAIT_TENS;
            if (pair_w > MAX) begin
                seg_err_d = 1'b1;
                cnt_d     = '0;
            end else begin
                // cnt_q == 0 means no candidate is held, even if cand_q happens to match
                if (cnt_q != '0 && pair_w[4:0] == cand_q) begin
                    cnt_d = cnt_q == STABLE ? cnt_q : cnt_q + 4'd1;
                end else begin
                    cand_d = pair_w[4:0];
                    cnt_d  = 4'd1;
                end
                if (cnt_d == STABLE && cand_d != count_q) begin
                    count_d = cand_d;
                    cv_d    = 1'b1;
`ifdef DISP_MON_SEQCHK_EN
                    seq_err_d = !(cand_d == count_q - 5'd1 || count_q == '0 || first_q);
                    first_d   = 1'b0;
`endif
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_BLANK;
            tens_q     <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            count_q    <= '0;
            cv_q       <= 1'b0;
            manual_q   <= 1'b1;
            seg_err_q  <= 1'b0;
            lamp_err_q <= 1'b0;
            prev_q     <= L_BAD;
`ifdef DISP_MON_SEQCHK_EN
            first_q    <= 1'b1;
            seq_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            cv_q       <= cv_d;
            manual_q   <= state_d == S_BLANK;
            seg_err_q  <= seg_err_d;
            lamp_err_q <= lamp_err_d;
            prev_q     <= lamp_cur;
`ifdef DISP_MON_SEQCHK_EN
            first_q    <= first_d;
            seq_err_q  <= seq_err_d;
`endif
        end
    end
    assign bus.count       = count_q;
    assign bus.count_valid = cv_q;
    assign bus.manual      = manual_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.lamp_err    = lamp_err_q;
`ifdef DISP_MON_SEQCHK_EN
    assign bus.seq_err     = seq_err_q;
`else
    assign bus.seq_err     = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_display_monitor.sv
// tb_traffic_display_monitor: scoreboard bench for the lane display monitor
module tb_traffic_display_monitor;
    import traffic_pkg::*;
`ifdef DISP_MON_SEQCHK_EN
    localparam logic SEQ_EN = 1'b1;
`else
    localparam logic SEQ_EN = 1'b0;
`endif
    typedef struct packed {
        logic       cv;
        logic [4:0] count;
        logic       seg;
        logic       seq;
        logic       lamp;
    } ev_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    traffic_display_monitor_if bus();
    traffic_display_monitor dut (.clk(clk), .reset(reset), .bus(bus));
    ev_t exp_q[$];
    ev_t e;
    int total = 0;
    int bad = 0;
    logic [7:0] digits [10];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask
    task automatic drive(input logic [1:0] c, input logic [7:0] s);
        bus.cs  = c;
        bus.seg = s;
        @(posedge clk);
        #1;
    endtask
    task automatic lamps(input logic d, input logic v, input logic x);
        bus.lamp_d = d;
        bus.lamp_v = v;
        bus.lamp_x = x;
    endtask
    task automatic expect_ev(input logic cv, input logic [4:0] n, input logic se, input logic sq, input logic le);
        exp_q.push_back({cv, n, se, sq, le});
    endtask
    task automatic pairs(input int t, input int u, input int n, input logic ev, input logic [4:0] val, input logic sq);
        for (int i = 0; i < n; i++) begin
            drive(CS_TENS, digits[t]);
            if (ev && i == n - 1) expect_ev(1'b1, val, 1'b0, sq, 1'b0);
            drive(CS_UNITS, digits[u]);
        end
    endtask
    always @(negedge clk) begin
        if (!reset && (bus.count_valid || bus.seg_err || bus.seq_err || bus.lamp_err)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got cv=%0b count=%0d seg=%0b seq=%0b lamp=%0b want none",
                         bus.count_valid, bus.count, bus.seg_err, bus.seq_err, bus.lamp_err);
            end else begin
                e = exp_q.pop_front();
                chk("count_valid", bus.count_valid, e.cv);
                if (e.cv) chk("count", bus.count, e.count);
                chk("seg_err", bus.seg_err, e.seg);
                chk("seq_err", bus.seq_err, e.seq);
                chk("lamp_err", bus.lamp_err, e.lamp);
            end
        end
    end
    initial begin
        digits = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
        lamps(1'b0, 1'b0, 1'b1);
        bus.cs  = CS_BLANK;
        bus.seg = SEG_DASH;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_count_valid", bus.count_valid, 0);
        chk("rst_manual", bus.manual, 1);
        chk("rst_seg_err", bus.seg_err, 0);
        chk("rst_seq_err", bus.seq_err, 0);
        chk("rst_lamp_err", bus.lamp_err, 0);
        reset = 1'b0;
        pairs(2, 2, 4, 1'b1, 5'd22, 1'b0);
        pairs(2, 1, 4, 1'b1, 5'd21, 1'b0);
        pairs(1, 9, 4, 1'b1, 5'd19, SEQ_EN);
        pairs(2, 0, 4, 1'b1, 5'd20, SEQ_EN);
        pairs(2, 1, 1, 1'b0, 5'd0, 1'b0);
        pairs(2, 0, 4, 1'b0, 5'd0, 1'b0);
        chk("filter_count", bus.count, 20);
        drive(CS_TENS, SEG_1);
        expect_ev(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        drive(CS_TENS, 8'hFF);
        drive(CS_UNITS, SEG_9);
        pairs(1, 9, 3, 1'b1, 5'd19, 1'b0);
        expect_ev(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        drive(2'b00, SEG_1);
        expect_ev(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        drive(CS_BLANK, SEG_0);
        chk("bad_blank_manual", bus.manual, 0);
        drive(CS_BLANK, SEG_DASH);
        chk("dash_manual", bus.manual, 1);
        pairs(1, 5, 4, 1'b1, 5'd15, 1'b0);
        chk("scan_manual", bus.manual, 0);
        for (int i = 0; i < 2; i++) begin
            drive(CS_TENS, SEG_3);
            expect_ev(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            drive(CS_UNITS, SEG_0);
        end
        drive(CS_UNITS, SEG_0);
        chk("overmax_count", bus.count, 15);
        lamps(1'b0, 1'b1, 1'b0);
        drive(CS_UNITS, SEG_0);
        lamps(1'b1, 1'b0, 1'b0);
        drive(CS_UNITS, SEG_0);
        lamps(1'b0, 1'b0, 1'b1);
        drive(CS_UNITS, SEG_0);
        expect_ev(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        lamps(1'b1, 1'b0, 1'b0);
        drive(CS_UNITS, SEG_0);
        expect_ev(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        lamps(1'b1, 1'b0, 1'b1);
        drive(CS_UNITS, SEG_0);
        lamps(1'b0, 1'b0, 1'b1);
        repeat (5) drive(CS_UNITS, SEG_0);
        chk("pending_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
